// File: rtl/hour_entry_decoder.sv
// Converts a keyed two-digit BCD hour plus an AM/PM selection into the binary
// 0..MODULO-1 value loaded by the hour counter, validating it against the 12/24 mode.
module hour_entry_decoder #(
  parameter int MODULO = 24,
  parameter int BITS   = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            digit_valid,
  input  logic [3:0]      digit_bcd,
  input  logic            mode,
  input  logic            ampm_sel,
  input  logic            cancel,
  output logic            load,
  output logic            error,
  output logic            busy,
  output logic [BITS-1:0] hour_binary,
  output logic [7:0]      entry_bcd,
  output logic [6:0]      ampm_7seg,
  output logic [1:0]      state_dbg
);

  // Handshake: digit_valid is a single-cycle strobe with no back-pressure.
  // A digit is accepted in IDLE (tens) and TENS (units); it is dropped in CHECK.
  // load/error are single-cycle strobes, mutually exclusive, issued two edges
  // after the units digit is sampled.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TENS  = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam logic [7:0] MOD_V    = 8'(MODULO);
  localparam logic [6:0] SEG_A    = 7'b000_1000;
  localparam logic [6:0] SEG_P    = 7'b000_1100;
  localparam logic [6:0] SEG_OFF  = 7'b111_1111;

  state_t          state, state_n;
  logic [7:0]      entry_n;
  logic [BITS-1:0] hour_n;
  logic            load_n, error_n;
  logic            mode_q, ampm_q, mode_n, ampm_n;

  logic [3:0]      tens, units;
  logic [7:0]      value;
  logic            dec_ok;
  logic [BITS-1:0] dec_hour;

  // Decode of the held digits; only consumed while in CHECK.
  always_comb begin
    tens     = entry_bcd[7:4];
    units    = entry_bcd[3:0];
    value    = {4'b0000, tens} * 8'd10 + {4'b0000, units};
    dec_ok   = 1'b0;
    dec_hour = '0;
    if (tens <= 4'd9 && units <= 4'd9) begin
      if (!mode) begin
        dec_ok   = (value < MOD_V);
        dec_hour = BITS'(value);
      end else begin
        dec_ok = (value >= 8'd1) && (value <= 8'd12);
        if (ampm_sel)
          dec_hour = BITS'(value + 8'd11);
        else
          dec_hour = BITS'(value - 8'd1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    entry_n = entry_bcd;
    hour_n  = hour_binary;
    load_n  = 1'b0;
    error_n = 1'b0;
    mode_n  = mode_q;
    ampm_n  = ampm_q;
    case (state)
      IDLE: begin
        if (cancel) begin
          entry_n = 8'h00;
        end else if (digit_valid) begin
          entry_n = {digit_bcd, 4'h0};
          state_n = TENS;
        end
      end
      TENS: begin
        if (cancel) begin
          entry_n = 8'h00;
          state_n = IDLE;
        end else if (digit_valid) begin
          entry_n[3:0] = digit_bcd;
          state_n      = CHECK;
        end
      end
      CHECK: begin
        state_n = IDLE;
        mode_n  = mode;
        ampm_n  = ampm_sel;
        if (dec_ok) begin
          load_n = 1'b1;
          hour_n = dec_hour;
        end else begin
          error_n = 1'b1;
          entry_n = 8'h00;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      entry_bcd   <= 8'h00;
      hour_binary <= '0;
      load        <= 1'b0;
      error       <= 1'b0;
      mode_q      <= 1'b0;
      ampm_q      <= 1'b0;
    end else begin
      entry_bcd   <= entry_n;
      hour_binary <= hour_n;
      load        <= load_n;
      error       <= error_n;
      mode_q      <= mode_n;
      ampm_q      <= ampm_n;
    end
  end

  // Indicator follows the mode/AM-PM captured at the most recent CHECK.
  always_comb begin
    if (!mode_q)
      ampm_7seg = SEG_OFF;
    else if (ampm_q)
      ampm_7seg = SEG_P;
    else
      ampm_7seg = SEG_A;
  end

  assign busy      = (state == TENS) || (state == CHECK);
  assign state_dbg = state;

endmodule

// File: doc/hour_entry_decoder.md
Name: hour_entry_decoder

Overview:
Decodes a user-keyed hour, given as two BCD digits plus an AM/PM selection, into the binary modulo-24 hour value that the hour counter loads. It is the inverse of the hour display path: display-format BCD in, counter-format binary out. It sits between the key/digit scanner and the hour counter's parallel-load input. It checks each entry against the active 12/24 mode before issuing a one-cycle load strobe.

Parameters:
MODULO, 24, hour count range; a valid binary result is 0..MODULO-1
BITS, 8, width of hour_binary

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low; clears all state and outputs
digit_valid  input  1  single-cycle strobe; digit_bcd is valid
digit_bcd  input  4  BCD digit; the first accepted digit is tens, the second is units
mode  input  1  0 = 24-hour entry, 1 = 12-hour entry
ampm_sel  input  1  12-hour only: 0 = AM, 1 = PM
cancel  input  1  aborts the entry in progress
load  output  1  one-cycle strobe; hour_binary holds a new valid value
error  output  1  one-cycle strobe; entry rejected
busy  output  1  high while an entry is in progress
hour_binary  output  BITS  decoded hour in counter format
entry_bcd  output  8  {tens, units} echo for the display
ampm_7seg  output  7  active-low segment code: A = 000_1000, P = 000_1100, blank = 111_1111

Behaviour:
- Reset (reset = 0, asynchronous) values:
  - state IDLE
  - load = 0, error = 0, busy = 0
  - hour_binary = 0, entry_bcd = 8'h00, ampm_7seg = 111_1111
- FSM states:
  - IDLE: digit_valid -> store digit in entry_bcd[7:4], clear entry_bcd[3:0], go to TENS.
  - TENS: digit_valid -> store digit in entry_bcd[3:0], go to CHECK.
  - CHECK: unconditional, one cycle; registers load or error, then returns to IDLE.
- busy = 1 in TENS and CHECK.
- digit_valid in CHECK is ignored (dropped).
- Priority: cancel over digit_valid. In IDLE or TENS, cancel clears entry_bcd to 8'h00, goes to IDLE, and raises no error. cancel has no effect in CHECK.
- Latency: units digit sampled at edge k -> load or error is high for exactly the cycle after edge k+1. hour_binary updates at the same edge as load.
- mode and ampm_sel are sampled only in CHECK; changes during TENS have no effect on the digits already held.
- Decode in CHECK, with v = tens*10 + units, computed in at least 7 bits:
  - Any digit > 9 -> error.
  - mode = 0: v < MODULO -> hour_binary = v; otherwise error.
  - mode = 1: v must be 1..12, otherwise error.
    - AM: hour_binary = v - 1 (AM 1 -> 0, AM 12 -> 11).
    - PM: hour_binary = v + 11 (PM 1 -> 12, PM 12 -> 23).
    - This matches the counter display convention: count 0..11 shows AM count+1; count 12..23 shows PM count-11.
- On error: hour_binary keeps its previous value, load = 0, entry_bcd is cleared to 8'h00 at the same edge.
- On load: entry_bcd keeps the accepted digits until the next digit or cancel.
- ampm_7seg is combinational from the registered mode and ampm_sel captured at the last CHECK:
  - blank when the captured mode = 0
  - A when the captured mode = 1 and AM
  - P when the captured mode = 1 and PM
- load and error are never high in the same cycle.
- Reset asserted mid-entry aborts immediately; no strobe is produced.

Test Plan:
- 24h: mode = 0, digits 2 then 3 -> load high one cycle, two edges after the units digit; hour_binary = 23; entry_bcd = 8'h23; ampm_7seg = 111_1111.
- 24h out-of-range and bad digit: digits 2, 4 -> error pulse, hour_binary unchanged, entry_bcd = 8'h00. Digits 1, 4'hA -> error.
- 12h boundaries:
  - AM 12 -> hour_binary = 11, ampm_7seg = 000_1000.
  - PM 01 -> hour_binary = 12, ampm_7seg = 000_1100.
  - PM 12 -> hour_binary = 23.
  - AM 00 and PM 13 -> error.
- Cancel and priority: digit 1, then cancel and digit_valid in the same cycle -> IDLE, busy = 0, entry_bcd = 8'h00, no load or error. The next digits 0, 5 -> load with hour_binary = 5.
- Reset mid-entry: digit 1, then reset low for 3 ns between edges -> all outputs at reset values immediately. After release, digits 0, 7 -> load with hour_binary = 7.
- Late inputs: toggle mode and ampm_sel during TENS, digit_valid during CHECK -> decode uses the values present in CHECK, and the extra digit is dropped (state IDLE, no strobe).
